// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD display path.
// Holds digit geometry, the converter state type and display codes.
package bcd_pkg;

    localparam int BCD_W      = 4;
    localparam int DEF_DIGITS = 4;
    localparam int BCD_MAX    = 9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Non-numeric glyph codes understood by the segment decoder.
    localparam logic [3:0] BLANK = 4'hF;
    localparam logic [3:0] G     = 4'hA;
    localparam logic [3:0] b     = 4'hB;
    localparam logic [3:0] U     = 4'hC;
    localparam logic [3:0] F     = 4'hD;
    localparam logic [3:0] S     = 4'hE;

    function automatic int unsigned pow10(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3.
// Ports: digit (4-bit BCD in), adj (4-bit corrected out).
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] adj
);

    always_comb begin
        adj = digit;
        if (digit >= 4'd5) adj = digit + 4'd3;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter, one bit per clock.
// Ports: clk, rst_n (sync), start/bin in; busy, done pulse, bcd, ovf out.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = DEF_DIGITS,
    parameter int CNT_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam int          SW      = BCD_W * DIGITS;
    localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;

    state_t            state;
    logic [SW-1:0]     scratch;
    logic [SW-1:0]     adj;
    logic [BIN_W-1:0]  shreg;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_pend;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .digit (scratch[i*BCD_W +: BCD_W]),
            .adj   (adj[i*BCD_W +: BCD_W])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
            scratch  <= '0;
            shreg    <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= bin;
                        scratch  <= '0;
                        ovf_pend <= 32'(bin) > MAX_VAL;
                        cnt      <= CNT_W'(BIN_W);
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    // Corrected digits shift up, taking the next binary MSB.
                    scratch <= {adj[SW-2:0], shreg[BIN_W-1]};
                    shreg   <= {shreg[BIN_W-2:0], 1'b0};
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= FINISH;
                end
                FINISH: begin
                    bcd   <= ovf_pend ? {DIGITS{4'h9}} : scratch;
                    ovf   <= ovf_pend;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, saturation, back-to-back,
// mid-conversion reset and a strided sweep against a division model.
module tb_bin_to_bcd_seq;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] bin   = '0;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(
        .BIN_W  (14),
        .DIGITS (4),
        .CNT_W  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic digits_ok(input logic [15:0] d);
        for (int i = 0; i < 4; i++)
            if (d[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // One conversion; bin is scrambled right after the start edge.
    task automatic run_conv(input int val, output logic [15:0] rb,
                            output logic ro, output int lat,
                            output int busy_cyc);
        @(negedge clk);
        start = 1'b1;
        bin   = 14'(val);
        @(posedge clk);
        #1;
        start    = 1'b0;
        bin      = 14'(val) ^ 14'h1555;
        lat      = 0;
        busy_cyc = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cyc++;
        end
        rb = bcd;
        ro = ovf;
    endtask

    logic [15:0] rb;
    logic        ro;
    int          lat;
    int          bc;
    int          pulses;
    int          vals[$];

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd",  32'(bcd),  32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        rst_n = 1'b1;

        // Zero input, latency and busy width
        run_conv(0, rb, ro, lat, bc);
        chk("zero_bcd", 32'(rb), 32'h0000);
        chk("zero_ovf", 32'(ro), 32'd0);
        chk("zero_lat", 32'(lat), 32'd15);
        chk("zero_busy", 32'(bc), 32'd15);
        @(posedge clk);
        #1;
        chk("zero_done_w", 32'(done), 32'd0);

        run_conv(1234, rb, ro, lat, bc);
        chk("v1234", {15'd0, ro, rb}, {15'd0, 1'b0, 16'h1234});
        run_conv(9999, rb, ro, lat, bc);
        chk("v9999", {15'd0, ro, rb}, {15'd0, 1'b0, 16'h9999});
        run_conv(10000, rb, ro, lat, bc);
        chk("v10000", {15'd0, ro, rb}, {15'd0, 1'b1, 16'h9999});
        chk("v10000_lat", 32'(lat), 32'd15);
        run_conv(16383, rb, ro, lat, bc);
        chk("v16383", {15'd0, ro, rb}, {15'd0, 1'b1, 16'h9999});
        run_conv(5, rb, ro, lat, bc);
        chk("v5", {15'd0, ro, rb}, {15'd0, 1'b0, 16'h0005});

        // Start held high, bin changed mid-conversion
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd42;
        @(posedge clk);
        #1;
        bin = 14'd77;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_first", 32'(bcd), 32'h0042);
        chk("b2b_lat1", 32'(lat), 32'd15);
        @(posedge clk);
        #1;
        chk("b2b_done_w", 32'(done), 32'd0);
        chk("b2b_restart", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk("b2b_second", 32'(bcd), 32'h0077);
        chk("b2b_lat2", 32'(lat), 32'd15);
        @(posedge clk);
        #1;
        chk("b2b_done_w2", 32'(done), 32'd0);
        chk("b2b_idle", 32'(busy), 32'd0);

        // Reset during iteration 7 of converting 500
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd500;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bcd",  32'(bcd),  32'd0);
        chk("mid_rst_ovf",  32'(ovf),  32'd0);
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("mid_rst_nodone", 32'(pulses), 32'd0);
        run_conv(500, rb, ro, lat, bc);
        chk("v500", {15'd0, ro, rb}, {15'd0, 1'b0, 16'h0500});

        // Strided sweep plus the saturation boundary
        for (int v = 0; v < 16384; v += 61) vals.push_back(v);
        vals.push_back(9998);
        vals.push_back(9999);
        vals.push_back(10000);
        vals.push_back(10001);
        vals.push_back(16382);
        vals.push_back(16383);
        foreach (vals[i]) begin
            run_conv(vals[i], rb, ro, lat, bc);
            chk($sformatf("sweep_%0d", vals[i]), {15'd0, ro, rb},
                {15'd0, (vals[i] > 9999) ? 1'b1 : 1'b0, ref_bcd(vals[i])});
            chk($sformatf("digits_%0d", vals[i]), 32'(digits_ok(rb)), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
